// File: rtl/exp_lut_pkg.sv
// Shared constants and elaboration-time real<->fixed helpers for the e^x lookup pipeline.
// Used by exp_pipe_lut and exp_seg_rom (interpolation selected by EXP_PIPE_LUT_INTERP_EN).
package exp_lut_pkg;

   function automatic int max_code(input int total_bits);
      return (1 << (total_bits - 1)) - 1;
   endfunction

   function automatic int seg_frac(input int total_bits, input int seg_bits);
      return total_bits - seg_bits;
   endfunction

   function automatic real real_from_fixed(input int code, input int fx_bits);
      return real'(code) / real'(1 << fx_bits);
   endfunction

   // Round to nearest and clamp into [0, lim]; clamping in the real domain avoids int overflow.
   function automatic int fixed_from_real(input real v, input int fx_bits, input int lim);
      real scaled;
      scaled = $floor(v * real'(1 << fx_bits) + 0.5);
      if (scaled > real'(lim)) return lim;
      if (scaled < 0.0) return 0;
      return int'(scaled);
   endfunction

   function automatic int base_code(input int seg, input int total_bits, input int fx_bits,
                                    input int seg_bits);
      real xr;
      xr = real_from_fixed(seg * (1 << seg_frac(total_bits, seg_bits)), fx_bits);
      return fixed_from_real($exp(xr), fx_bits, max_code(total_bits));
   endfunction

   // Smallest signed code whose exact e^x exceeds MAX; 2^(TOTAL_BITS-1) if no code does.
   function automatic int x_ovf(input int total_bits, input int fx_bits);
      int res;
      res = 1 << (total_bits - 1);
      for (int c = (1 << (total_bits - 1)) - 1; c >= -(1 << (total_bits - 1)); c--) begin
         if ($exp(real_from_fixed(c, fx_bits)) * real'(1 << fx_bits) > real'(max_code(total_bits)))
            res = c;
      end
      return res;
   endfunction

endpackage

// File: rtl/exp_seg_rom.sv
// Registered segment ROM: base (and slope when EXP_PIPE_LUT_INTERP_EN) plus overflow flag.
// Contents are computed at elaboration from real-valued exp().
module exp_seg_rom
   import exp_lut_pkg::*;
#(
   parameter int TOTAL_BITS = 8,
   parameter int FX_BITS    = 4,
   parameter int SEG_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [TOTAL_BITS-1:0] x,
   output logic [TOTAL_BITS-1:0] base,
   output logic                  ovf
`ifdef EXP_PIPE_LUT_INTERP_EN
   ,
   output logic [TOTAL_BITS-1:0] slope
`endif
);

   localparam int NSEG  = 1 << SEG_BITS;
   localparam int X_OVF = x_ovf(TOTAL_BITS, FX_BITS);

   logic [TOTAL_BITS-1:0] base_rom [NSEG];
   logic [SEG_BITS-1:0]   seg;
   logic                  ovf_d;

`ifdef EXP_PIPE_LUT_INTERP_EN
   logic [TOTAL_BITS-1:0] slope_rom [NSEG];
`endif

   // Table index is the raw segment bits; S is its signed value.
   for (genvar i = 0; i < NSEG; i++) begin : g_rom
      localparam int S = (i >= NSEG / 2) ? i - NSEG : i;
      localparam int B = base_code(S, TOTAL_BITS, FX_BITS, SEG_BITS);
      assign base_rom[i] = TOTAL_BITS'(B);
`ifdef EXP_PIPE_LUT_INTERP_EN
      localparam int BN = (S == NSEG / 2 - 1) ? B : base_code(S + 1, TOTAL_BITS, FX_BITS, SEG_BITS);
      assign slope_rom[i] = TOTAL_BITS'(BN - B);
`endif
   end

   assign seg   = x[TOTAL_BITS-1 -: SEG_BITS];
   assign ovf_d = ($signed(x) >= X_OVF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base  <= '0;
         ovf   <= 1'b0;
`ifdef EXP_PIPE_LUT_INTERP_EN
         slope <= '0;
`endif
      end else if (rd_en) begin
         base  <= base_rom[seg];
         ovf   <= ovf_d;
`ifdef EXP_PIPE_LUT_INTERP_EN
         slope <= slope_rom[seg];
`endif
      end
   end

endmodule

// File: rtl/exp_pipe_lut.sv
// Three-stage e^x pipeline with a single shared advance enable (valid/ready on both sides).
// Define EXP_PIPE_LUT_INTERP_EN for linear interpolation; otherwise output is the segment base.
module exp_pipe_lut
   import exp_lut_pkg::*;
#(
   parameter int TOTAL_BITS = 8,
   parameter int FX_BITS    = 4,
   parameter int SEG_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TOTAL_BITS-1:0] x_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [TOTAL_BITS-1:0] exp_out,
   output logic                  ovf_out
);

   logic                  adv;
   logic                  s1_valid;
   logic [TOTAL_BITS-1:0] s1_x;
   logic                  s2_valid;
   logic [TOTAL_BITS-1:0] s2_base;
   logic                  s2_ovf;
   logic [TOTAL_BITS-1:0] result;

`ifdef EXP_PIPE_LUT_INTERP_EN
   localparam int SEG_FRAC = seg_frac(TOTAL_BITS, SEG_BITS);
   localparam int PW       = TOTAL_BITS + SEG_FRAC;
   localparam int MAX      = max_code(TOTAL_BITS);

   logic [TOTAL_BITS-1:0] s2_slope;
   logic [SEG_FRAC-1:0]   s2_frac;
   logic [PW-1:0]         prod;
   logic [TOTAL_BITS:0]   sum;
`endif

   // Every stage moves together; a stalled output freezes the whole pipe.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_x     <= x_in;
      end
   end

   exp_seg_rom #(
      .TOTAL_BITS(TOTAL_BITS),
      .FX_BITS   (FX_BITS),
      .SEG_BITS  (SEG_BITS)
   ) u_rom (
      .clk  (clk),
      .rst_n(rst_n),
      .rd_en(adv),
      .x    (s1_x),
      .base (s2_base),
      .ovf  (s2_ovf)
`ifdef EXP_PIPE_LUT_INTERP_EN
      ,
      .slope(s2_slope)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
`ifdef EXP_PIPE_LUT_INTERP_EN
         s2_frac  <= '0;
`endif
      end else if (adv) begin
         s2_valid <= s1_valid;
`ifdef EXP_PIPE_LUT_INTERP_EN
         s2_frac  <= s1_x[SEG_FRAC-1:0];
`endif
      end
   end

   always_comb begin
`ifdef EXP_PIPE_LUT_INTERP_EN
      prod   = PW'(s2_slope) * PW'(s2_frac);
      sum    = {1'b0, s2_base} + (TOTAL_BITS + 1)'(prod >> SEG_FRAC);
      result = (sum > (TOTAL_BITS + 1)'(MAX)) ? TOTAL_BITS'(MAX) : sum[TOTAL_BITS-1:0];
`else
      result = s2_base;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         exp_out   <= '0;
         ovf_out   <= 1'b0;
      end else if (adv) begin
         out_valid <= s2_valid;
         exp_out   <= result;
         ovf_out   <= s2_ovf;
      end
   end

endmodule

// File: tb/tb_exp_pipe_lut.sv
// Directed and swept checks of exp_pipe_lut at default parameters; model follows
// EXP_PIPE_LUT_INTERP_EN the same way as the design build.
module tb_exp_pipe_lut;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] x_in = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] exp_out;
   logic       ovf_out;

   int checks = 0;
   int failures = 0;
   int delivered = 0;
   logic [8:0] sbq[$];

   logic [7:0] bx[8];
   logic [7:0] be[8];
   logic       bo[8];

   exp_pipe_lut #(
      .TOTAL_BITS(8),
      .FX_BITS   (4),
      .SEG_BITS  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .exp_out  (exp_out),
      .ovf_out  (ovf_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // round(16*e^s) clamped to [0,127], hand-computed
   function automatic int base_of(input int s);
      case (s)
         -3:      return 1;
         -2:      return 2;
         -1:      return 6;
         0:       return 16;
         1:       return 43;
         2:       return 118;
         default: return (s > 2) ? 127 : 0;
      endcase
   endfunction

   function automatic logic [8:0] model(input logic [7:0] x);
      int s, f, b, r;
      s = int'($signed(x[7:4]));
      f = int'(x[3:0]);
      b = base_of(s);
`ifdef EXP_PIPE_LUT_INTERP_EN
      r = b + ((((s == 7) ? 0 : base_of(s + 1) - b) * f) / 16);
      if (r > 127) r = 127;
`else
      r = b;
`endif
      return {($signed(x) >= 34), 8'(r)};
   endfunction

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("sb_spurious", 1, 0);
            end else begin
               e = sbq.pop_front();
               check("sb_exp", exp_out, e[7:0]);
               check("sb_ovf", ovf_out, e[8]);
            end
            delivered++;
         end
         if (in_valid && in_ready) sbq.push_back(model(x_in));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] e, input logic o);
      check({tag, "_v"}, out_valid, 1);
      check({tag, "_exp"}, exp_out, e);
      check({tag, "_ovf"}, ovf_out, o);
   endtask

   // Back-to-back burst of n vectors from bx; result j must appear 3 edges after its accept.
   task automatic burst(input string tag, input int n);
      for (int c = 0; c < n + 2; c++) begin
         in_valid = (c < n);
         if (c < n) x_in = bx[c];
         step();
         if (c + 1 >= 3) expect_out(tag, be[c - 2], bo[c - 2]);
         else check({tag, "_lat"}, out_valid, 0);
      end
      in_valid = 1'b0;
      step();
      check({tag, "_idle"}, out_valid, 0);
   endtask

   initial begin
      logic [7:0] vec[6];
      logic [7:0] perm[256];
      logic [7:0] tmp;
      logic [8:0] held;
      int idx, d0, j;
      logic acc;

      repeat (2) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_exp", exp_out, 0);
      check("rst_ovf", ovf_out, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      bx[0] = 8'h00; be[0] = 8'h10; bo[0] = 1'b0;
      bx[1] = 8'h10; be[1] = 8'h2B; bo[1] = 1'b0;
      bx[2] = 8'hF0; be[2] = 8'h06; bo[2] = 1'b0;
      burst("b2b", 3);

      bx[0] = 8'h08;
`ifdef EXP_PIPE_LUT_INTERP_EN
      be[0] = 8'd29;
`else
      be[0] = 8'd16;
`endif
      bo[0] = 1'b0;
      burst("mid_seg", 1);

      bx[0] = 8'h7F; be[0] = 8'h7F; bo[0] = 1'b1;
      bx[1] = 8'h21; be[1] = 8'd118; bo[1] = 1'b0;
      bx[2] = 8'h22; bo[2] = 1'b1;
`ifdef EXP_PIPE_LUT_INTERP_EN
      be[2] = 8'd119;
`else
      be[2] = 8'd118;
`endif
      bx[3] = 8'h80; be[3] = 8'h00; bo[3] = 1'b0;
      burst("bound", 4);

      // Stall the consumer for 4 cycles while a 6-entry stream is in progress
      vec = '{8'h00, 8'h10, 8'hF0, 8'h08, 8'h22, 8'h80};
      held = model(vec[1]);
      idx = 0;
      d0 = delivered;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 4 && c < 8);
         in_valid = (idx < 6);
         x_in = (idx < 6) ? vec[idx] : 8'h00;
         #1;
         if (c >= 4 && c < 8) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_exp", exp_out, held[7:0]);
            check("bp_hold_ovf", ovf_out, held[8]);
         end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_accepted", idx, 6);
      check("bp_delivered", delivered - d0, 6);

      // Reset with three results in flight
      in_valid = 1'b1; x_in = 8'h10; step();
      x_in = 8'h08; step();
      x_in = 8'hF0; step();
      in_valid = 1'b0;
      #1;
      check("rstmid_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", out_valid, 0);
      check("rstmid_ready", in_ready, 1);
      check("rstmid_exp", exp_out, 0);
      check("rstmid_ovf", ovf_out, 0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check("rstmid_stale", out_valid, 0);
      end
      bx[0] = 8'h10; be[0] = 8'h2B; bo[0] = 1'b0;
      burst("post_rst", 1);

      // Shuffled sweep of every code at full throughput
      for (int i = 0; i < 256; i++) perm[i] = 8'(i);
      for (int i = 0; i < 255; i++) begin
         j = int'($urandom_range(255, i));
         tmp = perm[i];
         perm[i] = perm[j];
         perm[j] = tmp;
      end
      d0 = delivered;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         x_in = perm[i];
         step();
      end
      in_valid = 1'b0;
      repeat (5) step();
      check("sweep_delivered", delivered - d0, 256);
      check("sweep_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
